// File: rtl/leve1_pkg.sv
// leve1_pkg: shared types and constants for the LEVE1 instruction-fetch stage.
//   if_entry_t      : one buffered fetch result, {pc, instr}
//   LEVE1_RESET_PC  : default PC loaded on reset
`ifndef XLEN
`define XLEN 64
`endif

package leve1_pkg;

    typedef struct packed {
        logic [`XLEN-1:0] pc;
        logic [31:0]      instr;
    } if_entry_t;

    localparam logic [`XLEN-1:0] LEVE1_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/leve1_if_fifo.sv
// leve1_if_fifo: DEPTH-entry synchronous FIFO of if_entry_t.
//   clk, rst : clock and synchronous active-high reset
//   push     : write data at the tail
//   data     : entry to write
//   pop      : remove the head entry
//   clear    : empty the FIFO; wins over push and pop
//   full     : DEPTH entries held
//   empty    : no entries held
//   count    : number of entries held
//   head     : oldest entry (undefined while empty)
module leve1_if_fifo
    import leve1_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  if_entry_t                data,
    input  logic                     pop,
    input  logic                     clear,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output if_entry_t                head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_r;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == '0);
    assign count   = count_r;
    assign head    = mem[rd_ptr];

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage carries data only; occupancy is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (do_push && !clear && !rst) mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/leve1_if.sv
// leve1_if: instruction-fetch stage of the LEVE1 pipeline.
// Issues sequential instruction-memory reads under a credit limit of DEPTH
// (buffered + in-flight), buffers returned words with their PCs and presents
// one instruction per cycle downstream.
//   CLK, RST           : clock, synchronous active-high reset
//   IPC_WE, INEXT_PC   : load PC from redirect target (aligned to 4 bytes)
//   IFLASH             : discard buffered and in-flight fetches
//   IMEM_REQ/ADDR/ACK  : read request handshake
//   IMEM_RVALID/RDATA  : in-order read response
//   OVALID/OPC/OINSTR  : presented instruction, IREADY accepts it
module leve1_if
    import leve1_pkg::*;
#(
    parameter logic [`XLEN-1:0] RESET_PC = LEVE1_RESET_PC,
    parameter int               DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IPC_WE,
    input  logic [`XLEN-1:0] INEXT_PC,
    input  logic             IFLASH,
    output logic             IMEM_REQ,
    output logic [`XLEN-1:0] IMEM_ADDR,
    input  logic             IMEM_ACK,
    input  logic             IMEM_RVALID,
    input  logic [31:0]      IMEM_RDATA,
    output logic             OVALID,
    input  logic             IREADY,
    output logic [`XLEN-1:0] OPC,
    output logic [31:0]      OINSTR
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [`XLEN-1:0] pc_r;
    logic [`XLEN-1:0] resp_pc_r;
    logic [`XLEN-1:0] target;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    drop;
    logic [CW-1:0]    count;
    logic [CW:0]      inflight;
    logic [CW-1:0]    acc_inc;
    logic [CW-1:0]    rsp_dec;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    if_entry_t        head;
    if_entry_t        wentry;

    assign target   = {INEXT_PC[`XLEN-1:2], 2'b00};

    // Buffered plus in-flight words never exceed DEPTH, so a response always has room.
    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign IMEM_REQ = !RST && !IPC_WE && !IFLASH && (inflight < (CW+1)'(DEPTH));
    assign IMEM_ADDR = pc_r;
    assign accept   = IMEM_REQ && IMEM_ACK;

    assign acc_inc  = {{(CW-1){1'b0}}, accept};
    assign rsp_dec  = {{(CW-1){1'b0}}, IMEM_RVALID};

    // Responses to wrong-path requests (drop>0) and any response in a flush cycle are discarded.
    assign push     = !RST && !IFLASH && IMEM_RVALID && (drop == '0);
    assign pop      = !RST && !IFLASH && OVALID && IREADY;
    assign wentry   = '{pc: resp_pc_r, instr: IMEM_RDATA};

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r        <= RESET_PC;
            resp_pc_r   <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding + acc_inc - rsp_dec;

            if (IPC_WE)      pc_r <= target;
            else if (accept) pc_r <= pc_r + `XLEN'(4);

            if (IPC_WE)    resp_pc_r <= target;
            else if (push) resp_pc_r <= resp_pc_r + `XLEN'(4);

            // On flush every request still in flight after this cycle must be dropped.
            if (IFLASH)                        drop <= outstanding - rsp_dec;
            else if (IMEM_RVALID && drop != '0) drop <= drop - 1'b1;
        end
    end

    leve1_if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (push),
        .data  (wentry),
        .pop   (pop),
        .clear (IFLASH),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head)
    );

    // Head storage is not reset, so outputs are forced to zero while nothing is presented.
    assign OVALID = !empty;
    assign OPC    = empty ? '0 : head.pc;
    assign OINSTR = empty ? '0 : head.instr;

endmodule

// File: tb/tb_leve1_if.sv
// tb_leve1_if: directed bench for leve1_if with a behavioural instruction
// memory and a scoreboard of expected {pc, instr} pairs checked on every
// accepted instruction.
`ifndef XLEN
`define XLEN 64
`endif

module tb_leve1_if;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             IPC_WE = 1'b0;
    logic [`XLEN-1:0] INEXT_PC = '0;
    logic             IFLASH = 1'b0;
    logic             IMEM_REQ;
    logic [`XLEN-1:0] IMEM_ADDR;
    logic             IMEM_ACK = 1'b0;
    logic             IMEM_RVALID = 1'b0;
    logic [31:0]      IMEM_RDATA = '0;
    logic             OVALID;
    logic             IREADY = 1'b0;
    logic [`XLEN-1:0] OPC;
    logic [31:0]      OINSTR;

    leve1_if dut (
        .CLK         (CLK),
        .RST         (RST),
        .IPC_WE      (IPC_WE),
        .INEXT_PC    (INEXT_PC),
        .IFLASH      (IFLASH),
        .IMEM_REQ    (IMEM_REQ),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_ACK    (IMEM_ACK),
        .IMEM_RVALID (IMEM_RVALID),
        .IMEM_RDATA  (IMEM_RDATA),
        .OVALID      (OVALID),
        .IREADY      (IREADY),
        .OPC         (OPC),
        .OINSTR      (OINSTR)
    );

    always #5 CLK = ~CLK;

    int nchecks = 0;
    int npass   = 0;
    int lat     = 1;

    typedef struct {
        logic [`XLEN-1:0] pc;
        logic [31:0]      instr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [`XLEN-1:0] addr;
        int               rdy;
    } pend_t;
    pend_t pend[$];

    function automatic logic [31:0] instr_of(input logic [`XLEN-1:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_pc(input logic [`XLEN-1:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        exp_q.push_back(e);
    endtask

    // Behavioural memory: acceptance in cycle k yields RVALID in cycle k+lat.
    initial begin
        int    cyc = 0;
        pend_t p;
        forever begin
            @(negedge CLK);
            cyc++;
            #1;
            if (RST) begin
                pend.delete();
                IMEM_RVALID = 1'b0;
            end else if (pend.size() > 0 && pend[0].rdy <= cyc) begin
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = instr_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                IMEM_RVALID = 1'b0;
            end
            #1;
            if (!RST && IMEM_REQ && IMEM_ACK) begin
                p.addr = IMEM_ADDR;
                p.rdy  = cyc + lat;
                pend.push_back(p);
            end
        end
    end

    // Monitor: every accepted instruction is compared with the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            #3;
            if (!RST && OVALID && IREADY && !IFLASH) begin
                if (exp_q.size() == 0) begin
                    nchecks++;
                    $display("FAIL unexpected_accept: got pc 0x%0h, expected no instruction", OPC);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_pc", OPC, e.pc);
                    chk("accept_instr", {32'h0, OINSTR}, {32'h0, e.instr});
                end
            end
            if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) begin
                nchecks++;
                $display("FAIL fifo_overflow: got push into full FIFO, expected none");
            end
        end
    end

    // Holds reset two cycles, checks reset outputs, returns at the release edge.
    task automatic do_reset;
        @(negedge CLK);
        RST = 1'b1; IPC_WE = 1'b0; IFLASH = 1'b0; IREADY = 1'b0;
        IMEM_ACK = 1'b1; INEXT_PC = '0;
        exp_q.delete();
        @(negedge CLK);
        #3;
        chk("rst_req", {63'h0, IMEM_REQ}, 64'h0);
        chk("rst_ovalid", {63'h0, OVALID}, 64'h0);
        chk("rst_opc", OPC, 64'h0);
        chk("rst_oinstr", {32'h0, OINSTR}, 64'h0);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Raises IREADY while the scoreboard holds entries; records the first accepted request.
    task automatic drain(input int budget, input bit need_req, output logic [`XLEN-1:0] first_addr);
        bit got = 1'b0;
        bit done = 1'b0;
        first_addr = '0;
        for (int i = 0; i < budget && !done; i++) begin
            if (exp_q.size() == 0 && (got || !need_req)) begin
                IREADY = 1'b0;
                done = 1'b1;
            end else begin
                IREADY = (exp_q.size() != 0);
                #2;
                if (!got && IMEM_REQ && IMEM_ACK) begin
                    got = 1'b1;
                    first_addr = IMEM_ADDR;
                end
                @(negedge CLK);
            end
        end
        if (!done) begin
            IREADY = 1'b0;
            nchecks++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [`XLEN-1:0] first;
        int               nreq;
        logic [`XLEN-1:0] addrs [4];

        // 1: reset release, 1-cycle memory, continuous IREADY.
        lat = 1;
        do_reset();
        IREADY = 1'b1;
        expect_pc(64'h8000_0000); expect_pc(64'h8000_0004); expect_pc(64'h8000_0008);
        #3;
        chk("t1_req_c0", {63'h0, IMEM_REQ}, 64'h1);
        chk("t1_addr_c0", IMEM_ADDR, 64'h8000_0000);
        chk("t1_ovalid_c0", {63'h0, OVALID}, 64'h0);
        @(negedge CLK); #3;
        chk("t1_ovalid_c1", {63'h0, OVALID}, 64'h0);
        @(negedge CLK); #3;
        chk("t1_ovalid_c2", {63'h0, OVALID}, 64'h1);
        chk("t1_opc_c2", OPC, 64'h8000_0000);
        @(negedge CLK); #3;
        chk("t1_opc_c3", OPC, 64'h8000_0004);
        @(negedge CLK); #3;
        chk("t1_opc_c4", OPC, 64'h8000_0008);
        @(negedge CLK);
        IREADY = 1'b0;
        chk("t1_scoreboard_empty", 64'(exp_q.size()), 64'h0);

        // 2: IREADY low, memory always ACKs: credit stops issue after 4 requests.
        do_reset();
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            #3;
            if (IMEM_REQ && IMEM_ACK) begin
                if (nreq < 4) addrs[nreq] = IMEM_ADDR;
                nreq++;
            end
            @(negedge CLK);
        end
        chk("t2_nreq", 64'(nreq), 64'd4);
        for (int i = 0; i < 4; i++) chk("t2_addr", addrs[i], 64'h8000_0000 + 64'(4 * i));
        #3;
        chk("t2_req_stalled", {63'h0, IMEM_REQ}, 64'h0);
        @(negedge CLK);
        for (int i = 0; i < 4; i++) expect_pc(64'h8000_0000 + 64'(4 * i));
        drain(20, 1'b1, first);
        chk("t2_resume_addr", first, 64'h8000_0010);

        // 3: 3-cycle memory, 2 outstanding, redirect + flush to a misaligned target.
        lat = 3;
        do_reset();
        @(negedge CLK);
        @(negedge CLK);
        IMEM_ACK = 1'b0; IPC_WE = 1'b1; IFLASH = 1'b1; INEXT_PC = 64'h8000_1002;
        #3;
        chk("t3_outstanding", 64'(dut.outstanding), 64'd2);
        chk("t3_req_flush", {63'h0, IMEM_REQ}, 64'h0);
        @(negedge CLK);
        IPC_WE = 1'b0; IFLASH = 1'b0; IMEM_ACK = 1'b1;
        expect_pc(64'h8000_1000); expect_pc(64'h8000_1004);
        drain(30, 1'b1, first);
        chk("t3_first_addr", first, 64'h8000_1000);

        // 4: head presented with IREADY during flush + redirect is never accepted.
        lat = 1;
        do_reset();
        repeat (7) @(negedge CLK);
        IREADY = 1'b1; IFLASH = 1'b1; IPC_WE = 1'b1; INEXT_PC = 64'h8000_2000;
        #3;
        chk("t4_ovalid_flush", {63'h0, OVALID}, 64'h1);
        chk("t4_opc_flush", OPC, 64'h8000_0000);
        @(negedge CLK);
        IREADY = 1'b0; IFLASH = 1'b0; IPC_WE = 1'b0;
        expect_pc(64'h8000_2000); expect_pc(64'h8000_2004);
        drain(20, 1'b1, first);
        chk("t4_first_addr", first, 64'h8000_2000);

        // 5: ACK withheld for 5 cycles: request held stable.
        do_reset();
        IMEM_ACK = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("t5_req_hold", {63'h0, IMEM_REQ}, 64'h1);
            chk("t5_addr_hold", IMEM_ADDR, 64'h8000_0000);
            chk("t5_pc_hold", dut.pc_r, 64'h8000_0000);
            @(negedge CLK);
        end
        IMEM_ACK = 1'b1;
        #3;
        chk("t5_addr_ack", IMEM_ADDR, 64'h8000_0000);
        @(negedge CLK); #3;
        chk("t5_addr_next", IMEM_ADDR, 64'h8000_0004);
        @(negedge CLK);
        IMEM_ACK = 1'b0;
        expect_pc(64'h8000_0000); expect_pc(64'h8000_0004);
        drain(20, 1'b0, first);

        // 6: reset together with flush while 2 requests are in flight.
        lat = 3;
        do_reset();
        @(negedge CLK);
        @(negedge CLK);
        IMEM_ACK = 1'b0; RST = 1'b1; IFLASH = 1'b1;
        #3;
        chk("t6_req", {63'h0, IMEM_REQ}, 64'h0);
        chk("t6_ovalid", {63'h0, OVALID}, 64'h0);
        chk("t6_opc", OPC, 64'h0);
        chk("t6_oinstr", {32'h0, OINSTR}, 64'h0);
        @(negedge CLK);
        RST = 1'b0; IFLASH = 1'b0; IMEM_ACK = 1'b1;
        #3;
        chk("t6_drop", 64'(dut.drop), 64'h0);
        chk("t6_outstanding", 64'(dut.outstanding), 64'h0);
        chk("t6_restart_addr", IMEM_ADDR, 64'h8000_0000);
        @(negedge CLK);
        expect_pc(64'h8000_0000); expect_pc(64'h8000_0004);
        drain(30, 1'b0, first);

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", npass, nchecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
